axo_uart_tx_arbiter: RTL and testbench
======================================

Name: axo_uart_tx_arbiter

Overview:
- Shares one UART transmit byte stream among n_req requesters, e.g. multiple harts or debug sources printing to one console.
- Round-robin arbitration, with message lock: a granted requester keeps the stream until it sends an end-of-line or last byte, or until it idles past a timeout.
- Output is a valid/ready byte stream that feeds the UART peripheral's TX write path; lines from different sources never interleave.

Parameters:
- n_req, 4, number of requesters; range 2..16.
- lock_timeout, 255, idle cycles a granted requester may hold the lock with req_valid low before the grant is revoked; must be >= 1.
- eol_byte, 8'h0A, byte value that ends a message and releases the lock.

Ports:
- clk  in  1  bus clock.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  n_req  per-requester byte valid.
- req_data  in  8*n_req  per-requester byte; requester i occupies bits [8i+7:8i].
- req_last  in  n_req  per-requester explicit end-of-message; same qualification as data.
- req_ready  out  n_req  per-requester accept.
- out_valid  out  1  byte valid towards the UART TX path.
- out_data  out  8  byte towards the UART TX path.
- out_ready  in  1  UART TX path accepts the byte (low while the TX FIFO is full).
- grant  out  n_req  one-hot current owner; all-zero when idle.
- busy  out  1  high while any grant is held.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Transfer rule: a transfer on a side occurs when valid && ready are high at a posedge clk.
- Requester obligations: data and last are held stable while valid && !ready. The arbiter does not check this.
- Reset values: state IDLE, grant = 0, busy = 0, out_valid = 0, req_ready = 0, idle counter = 0. Priority pointer = n_req-1, so requester 0 wins first.
- Reset mid-message: grant is dropped immediately and no transfer is counted in the reset cycle.
- State IDLE:
  - out_valid = 0, req_ready = 0.
  - If any req_valid is high, pick the first set bit searching from pointer+1 upward, wrapping modulo n_req.
  - Register the choice into grant and go to GRANT. Arbitration latency is exactly 1 cycle from req_valid to grant.
  - The pointer does not change in IDLE.
- State GRANT (owner g):
  - out_valid = req_valid[g], out_data = req_data[g], req_ready[g] = out_ready.
  - All other req_ready are 0. These paths are combinational; there is no added latency, so the output runs at 1 byte/cycle while valid and ready hold.
  - Release on a transfer where req_last[g] = 1 or req_data[g] == eol_byte: that byte is transferred, then next cycle state = IDLE, grant = 0, pointer = g.
  - Idle counter:
    - Clears on every transfer.
    - Increments on a cycle where req_valid[g] = 0.
    - Holds when req_valid[g] = 1 && out_ready = 0; a sink stall never revokes the grant.
  - Timeout: when the counter equals lock_timeout and req_valid[g] = 0, release as above (pointer = g, counter cleared).
  - Counter width is $clog2(lock_timeout+1) and it must not wrap.
- Simultaneous events:
  - Release byte and timeout condition in the same cycle: single normal release.
  - A release always costs one IDLE cycle before the next grant, including re-grant of the same requester when it is the only one requesting.
- Fairness: with all requesters continuously requesting one-byte messages, grants rotate 0,1,...,n_req-1,0.
- Starvation: worst-case wait is n_req-1 messages plus timeouts.
- busy = (state == GRANT).
- grant is always one-hot or zero.

Test Plan:
- Reset, then req_valid = 4'b1111, each requester sending 1 byte with last = 1, out_ready = 1 -> grant sequence 0001, 0010, 0100, 1000, 0001; each grant lasts 1 cycle, separated by 1 IDLE cycle.
- Req 2 sends "AB\n" (8'h41, 8'h42, 8'h0A) while req 0 is valid throughout -> out_data = 41, 42, 0A with no req 0 byte in between; req 0 is granted 2 cycles after the 0A transfer.
- Req 1 granted, sends 8'h41, then drops req_valid for 255 cycles -> grant released on the 255th idle cycle; pointer = 1, so req 3 wins over req 0 if both request.
- Req 1 granted with req_valid = 1 and out_ready held 0 for 1000 cycles -> grant is held, no timeout. Then out_ready = 1 -> byte transfers.
- Assert rst while req 3 is mid-message with out_ready = 1 -> next cycle grant = 0, out_valid = 0, and no byte is transferred in the reset cycle. After reset, req 0 wins first.
- Byte 8'h0A sent with req_last = 1 and the timeout condition coinciding -> exactly one release and one IDLE cycle; pointer = owner.

Source files
------------

// File: rtl/axo_uart_tx_arbiter.sv
// axo_uart_tx_arbiter
//   Shares one UART TX byte stream among n_req requesters. Round-robin
//   arbitration with a message lock: the owner keeps the stream until it
//   sends a byte flagged last, a byte equal to eol_byte, or stays idle
//   (req_valid low) long enough to hit the lock timeout.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid/data/last   per-requester byte stream (data lane i = [8i+7:8i])
//   req_ready             per-requester accept (only the owner can see 1)
//   out_valid/data/ready  merged byte stream towards the UART TX path
//   grant                 one-hot owner, zero while idle
//   busy                  a grant is held
module axo_uart_tx_arbiter #(
    parameter int         n_req        = 4,
    parameter int         lock_timeout = 255,
    parameter logic [7:0] eol_byte     = 8'h0A
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [n_req-1:0]   req_valid,
    input  logic [8*n_req-1:0] req_data,
    input  logic [n_req-1:0]   req_last,
    output logic [n_req-1:0]   req_ready,
    output logic               out_valid,
    output logic [7:0]         out_data,
    input  logic               out_ready,
    output logic [n_req-1:0]   grant,
    output logic               busy
);

    localparam int PTR_W = (n_req > 1) ? $clog2(n_req) : 1;
    localparam int CNT_W = (lock_timeout > 1) ? $clog2(lock_timeout + 1) : 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    // Idle count at which the next idle cycle revokes the lock; the counter
    // therefore never exceeds lock_timeout-1 and cannot wrap.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(lock_timeout - 1);

    logic [0:0]       state_q, state_d;
    logic [n_req-1:0] grant_q, grant_d;
    logic [PTR_W-1:0] ptr_q,   ptr_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    // Owner view: fields of the requester selected by grant_q.
    logic             own_valid;
    logic             own_last;
    logic [7:0]       own_data;
    logic [PTR_W-1:0] own_idx;

    always_comb begin
        own_valid = 1'b0;
        own_last  = 1'b0;
        own_data  = 8'h00;
        own_idx   = '0;
        for (int i = 0; i < n_req; i++) begin
            if (grant_q[i]) begin
                own_valid = req_valid[i];
                own_last  = req_last[i];
                own_data  = req_data[8*i +: 8];
                own_idx   = PTR_W'(i);
            end
        end
    end

    // Round-robin pick: first requesting index after the pointer, wrapping.
    logic             pick_found;
    logic [PTR_W-1:0] pick_idx;

    always_comb begin
        int idx;
        idx        = 0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 1; k <= n_req; k++) begin
            idx = (int'(ptr_q) + k) % n_req;
            if (!pick_found && req_valid[idx]) begin
                pick_found = 1'b1;
                pick_idx   = PTR_W'(idx);
            end
        end
    end

    // Outputs are gated by rst so nothing is handshaken in the reset cycle.
    logic xfer;

    always_comb begin
        busy      = (state_q == ST_GRANT);
        grant     = grant_q;
        out_valid = busy && own_valid && !rst;
        out_data  = own_data;
        req_ready = (busy && out_ready && !rst) ? grant_q : '0;
        xfer      = out_valid && out_ready;
    end

    logic rel;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        rel     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d = ST_GRANT;
                    grant_d = {{(n_req-1){1'b0}}, 1'b1} << pick_idx;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (xfer) begin
                    cnt_d = '0;
                    rel   = own_last || (own_data == eol_byte);
                end else if (!own_valid) begin
                    if (cnt_q == CNT_LAST) rel = 1'b1;
                    else                   cnt_d = cnt_q + CNT_W'(1);
                end
                // valid && !out_ready: sink stall, counter holds.
                if (rel) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    ptr_d   = own_idx;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= PTR_W'(n_req - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_axo_uart_tx_arbiter.sv
module tb_axo_uart_tx_arbiter;

    localparam int         N   = 4;
    localparam int         TO  = 255;
    localparam logic [7:0] EOL = 8'h0A;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           out_valid;
    logic [7:0]     out_data;
    logic           out_ready;
    logic [N-1:0]   grant;
    logic           busy;

    int checks   = 0;
    int failures = 0;

    axo_uart_tx_arbiter #(.n_req(N), .lock_timeout(TO), .eol_byte(EOL)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: owner index (-1 = nobody), rotation pointer, and the
    // number of consecutive cycles the owner has left req_valid low.
    int         m_owner;
    int         m_ptr;
    int         m_idle;
    logic [N-1:0] e_grant, e_rr;
    logic       e_busy, e_ov;
    logic [7:0] e_od;

    task automatic model_out();
        e_grant = '0;
        e_rr    = '0;
        e_busy  = (m_owner >= 0);
        e_ov    = 1'b0;
        e_od    = 8'h00;
        if (m_owner >= 0) begin
            e_grant[m_owner] = 1'b1;
            e_ov = !rst && req_valid[m_owner];
            e_od = req_data[8*m_owner +: 8];
            if (!rst && out_ready) e_rr[m_owner] = 1'b1;
        end
    endtask

    task automatic model_step();
        int o;
        if (rst) begin
            m_owner = -1; m_ptr = N - 1; m_idle = 0;
        end else if (m_owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                if (m_owner < 0 && req_valid[(m_ptr + k) % N]) begin
                    m_owner = (m_ptr + k) % N;
                    m_idle  = 0;
                end
            end
        end else begin
            o = m_owner;
            if (req_valid[o] && out_ready) begin
                m_idle = 0;
                if (req_last[o] || req_data[8*o +: 8] == EOL) begin
                    m_ptr = o; m_owner = -1;
                end
            end else if (!req_valid[o]) begin
                m_idle++;
                if (m_idle == TO) begin
                    m_ptr = o; m_owner = -1; m_idle = 0;
                end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL reset_grant got=%b exp=0000", grant); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_seq [10] = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1};
        do_reset();
        req_valid = 4'hF; req_last = 4'hF; out_ready = 1'b1;
        for (int i = 0; i < N; i++) req_data[8*i +: 8] = 8'h10 + 8'(i);
        for (int c = 0; c < 10; c++) begin
            #1;
            checks++;
            if (grant !== exp_seq[c]) begin
                failures++; $display("FAIL rr_grant cycle=%0d got=%b exp=%b", c, grant, exp_seq[c]);
            end
            tick();
        end
    endtask

    task automatic test_lock_eol();
        do_reset();
        out_ready = 1'b1;
        req_valid = 4'b0100; req_data[8*2 +: 8] = 8'h41; req_last = '0;
        #1; tick();
        req_valid = 4'b0101; req_data[8*0 +: 8] = 8'h30; req_last[0] = 1'b1;
        #1;
        checks++; if (out_data !== 8'h41 || req_ready !== 4'b0100) begin
            failures++; $display("FAIL eol_byte0 data=%h ready=%b exp=41 0100", out_data, req_ready); end
        tick();
        req_data[8*2 +: 8] = 8'h42; #1;
        checks++; if (out_data !== 8'h42 || grant !== 4'b0100) begin
            failures++; $display("FAIL eol_byte1 data=%h grant=%b exp=42 0100", out_data, grant); end
        tick();
        req_data[8*2 +: 8] = 8'h0A; #1;
        checks++; if (out_data !== 8'h0A || out_valid !== 1'b1) begin
            failures++; $display("FAIL eol_byte2 data=%h valid=%b exp=0a 1", out_data, out_valid); end
        tick();
        req_valid = 4'b0001; #1;
        checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL eol_idle got=%b exp=0000", grant); end
        tick(); #1;
        checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL eol_next got=%b exp=0001", grant); end
    endtask

    task automatic test_timeout();
        int held = 0;
        do_reset();
        out_ready = 1'b1;
        req_valid = 4'b0010; req_data[8*1 +: 8] = 8'h41; req_last = '0;
        #1; tick(); #1;
        checks++; if (grant !== 4'b0010 || out_data !== 8'h41) begin
            failures++; $display("FAIL to_grant grant=%b data=%h exp=0010 41", grant, out_data); end
        tick();
        req_valid = '0;
        for (int k = 0; k < TO; k++) begin
            #1; if (grant === 4'b0010) held++;
            tick();
        end
        #1;
        checks++; if (held !== TO) begin failures++; $display("FAIL to_held got=%0d exp=%0d", held, TO); end
        checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL to_release got=%b exp=0000", grant); end
        req_valid = 4'b1001; #1; tick(); #1;
        checks++; if (grant !== 4'b1000) begin failures++; $display("FAIL to_ptr got=%b exp=1000", grant); end
    endtask

    task automatic test_stall();
        int held = 0;
        do_reset();
        out_ready = 1'b0;
        req_valid = 4'b0010; req_data[8*1 +: 8] = 8'h55; req_last = 4'b0010;
        #1; tick();
        for (int k = 0; k < 1000; k++) begin
            #1; if (grant === 4'b0010 && out_valid === 1'b1 && req_ready === 4'b0000) held++;
            tick();
        end
        checks++; if (held !== 1000) begin failures++; $display("FAIL stall_held got=%0d exp=1000", held); end
        out_ready = 1'b1; #1;
        checks++; if (req_ready !== 4'b0010 || out_data !== 8'h55) begin
            failures++; $display("FAIL stall_xfer ready=%b data=%h exp=0010 55", req_ready, out_data); end
        tick(); req_valid = '0; #1;
        checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL stall_release got=%b exp=0000", grant); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b1;
        req_valid = 4'b1000; req_data[8*3 +: 8] = 8'h77; req_last = '0;
        #1; tick(); tick();
        rst = 1'b1; #1;
        checks++; if (out_valid !== 1'b0 || req_ready !== 4'b0000) begin
            failures++; $display("FAIL rstmid_xfer valid=%b ready=%b exp=0 0000", out_valid, req_ready); end
        tick();
        rst = 1'b0; req_valid = 4'b1001; #1;
        checks++; if (grant !== 4'b0000 || out_valid !== 1'b0) begin
            failures++; $display("FAIL rstmid_drop grant=%b valid=%b exp=0000 0", grant, out_valid); end
        tick(); #1;
        checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL rstmid_first got=%b exp=0001", grant); end
    endtask

    task automatic test_coincide();
        int held = 0;
        do_reset();
        out_ready = 1'b1;
        req_valid = 4'b0100; req_data[8*2 +: 8] = 8'h41; req_last = '0;
        #1; tick(); tick();
        req_valid = '0;
        for (int k = 0; k < TO - 1; k++) begin
            #1; if (grant === 4'b0100) held++;
            tick();
        end
        req_valid = 4'b0100; req_data[8*2 +: 8] = EOL; req_last = 4'b0100; #1;
        checks++; if (held !== TO - 1 || grant !== 4'b0100 || out_valid !== 1'b1) begin
            failures++; $display("FAIL coin_pre held=%0d grant=%b valid=%b exp=%0d 0100 1", held, grant, out_valid, TO - 1); end
        tick();
        req_valid = 4'b1100; req_data[8*2 +: 8] = 8'h31; req_data[8*3 +: 8] = 8'h33; req_last = 4'b1100; #1;
        checks++; if (grant !== 4'b0000 || busy !== 1'b0) begin
            failures++; $display("FAIL coin_idle grant=%b busy=%b exp=0000 0", grant, busy); end
        tick(); #1;
        checks++; if (grant !== 4'b1000) begin failures++; $display("FAIL coin_ptr got=%b exp=1000", grant); end
    endtask

    task automatic test_random();
        do_reset();
        m_owner = -1; m_ptr = N - 1; m_idle = 0;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 499) == 0);
            #1;
            model_out();
            checks++; if (grant !== e_grant) begin failures++; $display("FAIL rnd_grant c=%0d got=%b exp=%b", c, grant, e_grant); end
            checks++; if (busy !== e_busy) begin failures++; $display("FAIL rnd_busy c=%0d got=%b exp=%b", c, busy, e_busy); end
            checks++; if (out_valid !== e_ov) begin failures++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, out_valid, e_ov); end
            checks++; if (req_ready !== e_rr) begin failures++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, req_ready, e_rr); end
            if (e_ov) begin
                checks++; if (out_data !== e_od) begin failures++; $display("FAIL rnd_data c=%0d got=%h exp=%h", c, out_data, e_od); end
            end
            tick();
            for (int i = 0; i < N; i++) begin
                if (!(req_valid[i] && !e_rr[i])) begin
                    req_valid[i] = ($urandom_range(0, 3) != 0);
                    req_data[8*i +: 8] = ($urandom_range(0, 7) == 0) ? EOL : 8'($urandom_range(0, 255));
                    req_last[i] = ($urandom_range(0, 7) == 0);
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end
        rst = 1'b0;
    endtask

    initial begin
        m_owner = -1; m_ptr = N - 1; m_idle = 0;
        rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; out_ready = 1'b0;
        test_reset();
        test_round_robin();
        test_lock_eol();
        test_timeout();
        test_stall();
        test_reset_mid();
        test_coincide();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
